// File: rtl/logic_unit_nbit_pkg.sv
// Opcodes and helpers for the bitwise logic unit. The ALU opcode decoder
// imports the same package so both sides agree on the encoding.
package logic_unit_nbit_pkg;

  localparam int LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND  = 3'b000,
    LU_OR   = 3'b001,
    LU_XOR  = 3'b010,
    LU_XNOR = 3'b011,
    LU_NAND = 3'b100,
    LU_NOR  = 3'b101,
    LU_NOT  = 3'b110,
    LU_XACC = 3'b111
  } lu_op_e;

  // Without an accumulator, the accumulate opcode degrades to a plain XOR.
  function automatic lu_op_e lu_eff_op(input logic [LU_OP_W-1:0] op, input bit acc_en);
    lu_op_e e;
    e = lu_op_e'(op);
    if (!acc_en && e == LU_XACC) begin
      e = LU_XOR;
    end
    return e;
  endfunction

endpackage

// File: rtl/logic_op_comb.sv
// Purely combinational bitwise operation slice: (op, A, B, acc_op) -> result.
// Shared with the ALU's unregistered path, so it must stay free of state.
module logic_op_comb
  import logic_unit_nbit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  lu_op_e           op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] acc_op,
  output logic [WIDTH-1:0] result
);

  // Every op is bitwise, so each result bit depends only on its own column.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic w_bit;

    always_comb begin
      w_bit = 1'b0;
      unique case (op)
        LU_AND:  w_bit = A[gi] & B[gi];
        LU_OR:   w_bit = A[gi] | B[gi];
        LU_XOR:  w_bit = A[gi] ^ B[gi];
        LU_XNOR: w_bit = ~(A[gi] ^ B[gi]);
        LU_NAND: w_bit = ~(A[gi] & B[gi]);
        LU_NOR:  w_bit = ~(A[gi] | B[gi]);
        LU_NOT:  w_bit = ~A[gi];
        LU_XACC: w_bit = A[gi] ^ acc_op[gi];
        default: w_bit = 1'b0;
      endcase
    end

    assign result[gi] = w_bit;
  end

endmodule

// File: rtl/logic_unit_nbit.sv
// Registered N-bit bitwise logic unit with valid/ready handshake on both
// sides and a running XOR accumulator for checksum/parity work.
module logic_unit_nbit
  import logic_unit_nbit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit ACC_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LU_OP_W-1:0] op,
  input  logic               acc_clr,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Y,
  output logic               zero,
  output logic               parity,
  output logic [WIDTH-1:0]   acc
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_parity;

  logic             w_accept;
  lu_op_e           w_op;
  logic [WIDTH-1:0] w_acc_op;
  logic [WIDTH-1:0] w_result;

  // No skid buffer: a new beat enters only when the output slot frees up.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_op     = lu_eff_op(op, ACC_EN);

  logic_op_comb #(
    .WIDTH (WIDTH)
  ) u_op (
    .op     (w_op),
    .A      (A),
    .B      (B),
    .acc_op (w_acc_op),
    .result (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b1;
      r_parity    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_result;
      r_zero      <= (w_result == '0);
      r_parity    <= ^w_result;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  if (ACC_EN) begin : g_acc
    logic [WIDTH-1:0] r_acc;

    assign w_acc_op = acc_clr ? '0 : r_acc;

    // The accumulate op leaves acc equal to the new Y; acc_clr on any
    // other op simply zeroes it.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_acc <= '0;
      end else if (w_accept) begin
        if (w_op == LU_XACC) begin
          r_acc <= w_result;
        end else if (acc_clr) begin
          r_acc <= '0;
        end
      end
    end

    assign acc = r_acc;
  end else begin : g_no_acc
    logic w_unused_acc_clr;

    assign w_unused_acc_clr = acc_clr;
    assign w_acc_op         = '0;
    assign acc              = '0;
  end

  assign out_valid = r_out_valid;
  assign Y         = r_y;
  assign zero      = r_zero;
  assign parity    = r_parity;

endmodule

// File: tb/tb_logic_unit_nbit.sv
// Directed bench for logic_unit_nbit: an 8-bit accumulating instance and a
// 16-bit instance without accumulator, plus a short random handshake run.
module tb_logic_unit_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit, accumulator enabled
  logic        rst8 = 1'b1, in_valid8 = 1'b0, acc_clr8 = 1'b0, out_ready8 = 1'b1;
  logic [2:0]  op8 = 3'b000;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, zero8, parity8;
  logic [7:0]  y8, acc8;

  // 16-bit, accumulator disabled
  logic        rst16 = 1'b1, in_valid16 = 1'b0, acc_clr16 = 1'b0, out_ready16 = 1'b1;
  logic [2:0]  op16 = 3'b000;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, zero16, parity16;
  logic [15:0] y16, acc16;

  logic_unit_nbit #(.WIDTH(8), .ACC_EN(1'b1)) u_dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .acc_clr(acc_clr8), .A(a8), .B(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .Y(y8),
    .zero(zero8), .parity(parity8), .acc(acc8)
  );

  logic_unit_nbit #(.WIDTH(16), .ACC_EN(1'b0)) u_dut16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .op(op16), .acc_clr(acc_clr16), .A(a16), .B(b16),
    .out_valid(out_valid16), .out_ready(out_ready16), .Y(y16),
    .zero(zero16), .parity(parity16), .acc(acc16)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Source rule: a stalled beat must keep its payload until accepted.
  logic       p_stall = 1'b0;
  logic [2:0] p_op;
  logic [7:0] p_a, p_b;
  always @(negedge clk) begin
    if (!rst8 && p_stall) begin
      checks++;
      assert (in_valid8 && op8 === p_op && a8 === p_a && b8 === p_b) else begin
        errors++;
        $error("FAIL src_stable observed=%h expected=%h", {op8, a8, b8}, {p_op, p_a, p_b});
      end
    end
    p_stall = in_valid8 && !in_ready8;
    p_op    = op8;
    p_a     = a8;
    p_b     = b8;
  end

  function automatic logic [7:0] model8(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] accop);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a ^ b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~a;
      default: return a ^ accop;
    endcase
  endfunction

  initial begin
    logic [7:0] exp2 [8];
    logic [7:0] sq3 [4];
    logic [7:0] ex3 [4];
    logic [7:0] m_acc, m_q;
    logic       m_ov, m_qv, m_ready;
    int         accepted, delivered, budget;

    exp2 = '{8'h24, 8'hBD, 8'h99, 8'h66, 8'hDB, 8'h42, 8'h5A, 8'hA5};
    sq3  = '{8'h01, 8'h02, 8'h04, 8'h80};
    ex3  = '{8'h01, 8'h03, 8'h07, 8'h87};

    // 1: reset held two cycles while a source offers data
    in_valid8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C;
    cyc(); cyc();
    chk("rst_out_valid", {15'd0, out_valid8}, 16'd0);
    chk("rst_y", {8'd0, y8}, 16'h0000);
    chk("rst_zero", {15'd0, zero8}, 16'd1);
    chk("rst_parity", {15'd0, parity8}, 16'd0);
    chk("rst_acc", {8'd0, acc8}, 16'h0000);
    rst8 = 1'b0; in_valid8 = 1'b0;
    cyc();
    chk("rst_in_ready", {15'd0, in_ready8}, 16'd1);
    chk("rst_idle_valid", {15'd0, out_valid8}, 16'd0);

    // 2: all ops, A=A5 B=3C, full throughput
    in_valid8 = 1'b1; out_ready8 = 1'b1; acc_clr8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      op8 = 3'(i);
      #1;
      if (i == 0) chk("lat_pre_edge_y", {8'd0, y8}, 16'h0000);
      cyc();
      chk($sformatf("op%0d_y", i), {8'd0, y8}, {8'd0, exp2[i]});
      chk($sformatf("op%0d_valid", i), {15'd0, out_valid8}, 16'd1);
    end
    chk("xacc_acc", {8'd0, acc8}, 16'h00A5);

    in_valid8 = 1'b0;
    cyc();
    chk("drain_valid", {15'd0, out_valid8}, 16'd0);
    chk("drain_y_hold", {8'd0, y8}, 16'h00A5);

    // acc_clr on a non-accumulate op zeroes acc
    in_valid8 = 1'b1; op8 = 3'b000; acc_clr8 = 1'b1;
    cyc();
    chk("clr_and_y", {8'd0, y8}, 16'h0024);
    chk("clr_and_acc", {8'd0, acc8}, 16'h0000);

    // 3: XOR-accumulate stream
    op8 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      a8 = sq3[i]; acc_clr8 = (i == 0);
      cyc();
      chk($sformatf("xstream%0d_y", i), {8'd0, y8}, {8'd0, ex3[i]});
    end
    chk("xstream_acc", {8'd0, acc8}, 16'h0087);
    chk("xstream_parity", {15'd0, parity8}, 16'd0);
    a8 = 8'hFF; acc_clr8 = 1'b1;
    cyc();
    chk("xclr_y", {8'd0, y8}, 16'h00FF);
    chk("xclr_acc", {8'd0, acc8}, 16'h00FF);

    // 4: backpressure
    a8 = 8'h33; acc_clr8 = 1'b1;
    cyc();
    chk("bp_load_acc", {8'd0, acc8}, 16'h0033);
    out_ready8 = 1'b0; a8 = 8'h11; acc_clr8 = 1'b0;
    #1;
    chk("bp_in_ready_comb", {15'd0, in_ready8}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("bp%0d_in_ready", i), {15'd0, in_ready8}, 16'd0);
      chk($sformatf("bp%0d_y", i), {8'd0, y8}, 16'h0033);
      chk($sformatf("bp%0d_acc", i), {8'd0, acc8}, 16'h0033);
      chk($sformatf("bp%0d_valid", i), {15'd0, out_valid8}, 16'd1);
    end
    out_ready8 = 1'b1;
    #1;
    chk("bp_release_ready", {15'd0, in_ready8}, 16'd1);
    cyc();
    chk("bp_release_y", {8'd0, y8}, 16'h0022);
    chk("bp_release_acc", {8'd0, acc8}, 16'h0022);

    // 5: flags
    op8 = 3'b010; a8 = 8'h5A; b8 = 8'h5A;
    cyc();
    chk("flag_xor_y", {8'd0, y8}, 16'h0000);
    chk("flag_xor_zero", {15'd0, zero8}, 16'd1);
    chk("flag_xor_parity", {15'd0, parity8}, 16'd0);
    op8 = 3'b110; a8 = 8'hFE;
    cyc();
    chk("flag_not_y", {8'd0, y8}, 16'h0001);
    chk("flag_not_zero", {15'd0, zero8}, 16'd0);
    chk("flag_not_parity", {15'd0, parity8}, 16'd1);
    in_valid8 = 1'b0;
    cyc();

    // 4b: 16-beat random handshake run against a scoreboard
    m_acc = acc8; m_ov = out_valid8; m_qv = 1'b0; m_q = '0;
    accepted = 0; delivered = 0; budget = 0;
    in_valid8 = 1'b0;
    while ((accepted < 16 || delivered < 16) && budget < 300) begin
      budget++;
      if (!(in_valid8 && !(!m_ov || out_ready8))) begin
        in_valid8 = (accepted < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
        op8       = 3'($urandom_range(0, 7));
        a8        = 8'($urandom);
        b8        = 8'($urandom);
        acc_clr8  = ($urandom_range(0, 3) == 0);
      end
      out_ready8 = 1'($urandom_range(0, 1));
      #1;
      m_ready = !m_ov || out_ready8;
      chk("rnd_in_ready", {15'd0, in_ready8}, {15'd0, m_ready});
      chk("rnd_out_valid", {15'd0, out_valid8}, {15'd0, m_ov});
      if (m_ov && out_ready8) begin
        chk("rnd_y", {8'd0, y8}, {8'd0, m_q});
        delivered++;
        m_qv = 1'b0;
      end
      if (in_valid8 && m_ready) begin
        m_q  = model8(op8, a8, b8, acc_clr8 ? 8'h00 : m_acc);
        m_qv = 1'b1;
        if (op8 == 3'b111) m_acc = m_q;
        else if (acc_clr8) m_acc = 8'h00;
        accepted++;
        m_ov = 1'b1;
      end else if (out_ready8) begin
        m_ov = 1'b0;
      end
      cyc();
      chk("rnd_acc", {8'd0, acc8}, {8'd0, m_acc});
    end
    chk("rnd_delivered", 16'(delivered), 16'd16);
    chk("rnd_pending", {15'd0, m_qv}, 16'd0);
    in_valid8 = 1'b0; out_ready8 = 1'b1;

    // 6: WIDTH=16, ACC_EN=0
    rst16 = 1'b0;
    in_valid16 = 1'b1; op16 = 3'b111; acc_clr16 = 1'b1; a16 = 16'hF0F0; b16 = 16'h0FF0;
    cyc();
    chk("w16_xacc_y", y16, 16'hFF00);
    chk("w16_acc", acc16, 16'h0000);
    chk("w16_parity", {15'd0, parity16}, 16'd0);
    // mid-stall reset drops the pending result
    out_ready16 = 1'b0; op16 = 3'b000; acc_clr16 = 1'b0;
    cyc();
    chk("w16_stall_ready", {15'd0, in_ready16}, 16'd0);
    chk("w16_stall_y", y16, 16'hFF00);
    rst16 = 1'b1;
    cyc();
    chk("w16_rst_valid", {15'd0, out_valid16}, 16'd0);
    chk("w16_rst_y", y16, 16'h0000);
    chk("w16_rst_zero", {15'd0, zero16}, 16'd1);
    rst16 = 1'b0; in_valid16 = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
